// File: rtl/lfsr_prog.sv
// Runtime-programmable Fibonacci/Galois LFSR with byte-serial config,
// automatic all-zero lock-up recovery and hardware period measurement.
module lfsr_prog #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = 16'hB400,
  parameter logic             DEFAULT_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_data,
  input  logic             step_en,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic             lockup,
  output logic             period_done,
  output logic [31:0]      period_cnt
);

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] taps_reg;
  logic             mode_reg;
  logic [WIDTH-1:0] seed_sh_reg;
  logic [WIDTH-1:0] taps_sh_reg;
  logic [WIDTH-1:0] ref_seed_reg;
  logic [31:0]      cnt_reg;
  logic [31:0]      period_cnt_reg;
  logic             lockup_reg;
  logic             period_done_reg;

  logic [WIDTH-1:0] galois_next;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] seed_sh_next;
  logic [WIDTH-1:0] taps_sh_next;
  logic [31:0]      cnt_next;
  logic             ctrl_wr;
  logic             commit;
  logic             clear;

  genvar gi;

  // Galois: right shift, feed the outgoing LSB back into every tapped bit.
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_galois
      if (gi == WIDTH - 1) begin : g_top
        assign galois_next[gi] = state_reg[0] & taps_reg[gi];
      end else begin : g_mid
        assign galois_next[gi] = state_reg[gi+1] ^ (state_reg[0] & taps_reg[gi]);
      end
    end
  endgenerate

  assign fib_next   = {state_reg[WIDTH-2:0], ^(state_reg & taps_reg)};
  assign state_next = mode_reg ? galois_next : fib_next;
  assign cnt_next   = cnt_reg + 32'd1;

  // Shadow loads keep the low WIDTH bits of {shadow, byte}, so bytes arrive MSB first.
  generate
    if (WIDTH > 8) begin : g_shift_wide
      assign seed_sh_next = {seed_sh_reg[WIDTH-9:0], cfg_data};
      assign taps_sh_next = {taps_sh_reg[WIDTH-9:0], cfg_data};
    end else if (WIDTH == 8) begin : g_shift_byte
      assign seed_sh_next = cfg_data;
      assign taps_sh_next = cfg_data;
    end else begin : g_shift_narrow
      assign seed_sh_next = cfg_data[WIDTH-1:0];
      assign taps_sh_next = cfg_data[WIDTH-1:0];
    end
  endgenerate

  assign ctrl_wr = cfg_valid && (cfg_addr == 2'd2);
  assign commit  = ctrl_wr && cfg_data[1];
  assign clear   = ctrl_wr && cfg_data[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= DEFAULT_SEED;
      taps_reg        <= DEFAULT_TAPS;
      mode_reg        <= DEFAULT_MODE;
      seed_sh_reg     <= '0;
      taps_sh_reg     <= '0;
      ref_seed_reg    <= DEFAULT_SEED;
      cnt_reg         <= '0;
      period_cnt_reg  <= '0;
      lockup_reg      <= 1'b0;
      period_done_reg <= 1'b0;
    end else begin
      lockup_reg      <= 1'b0;
      period_done_reg <= 1'b0;

      if (cfg_valid && cfg_addr == 2'd0) seed_sh_reg <= seed_sh_next;
      if (cfg_valid && cfg_addr == 2'd1) taps_sh_reg <= taps_sh_next;
      if (ctrl_wr) mode_reg <= cfg_data[0];

      // A period completing in this cycle overrides the clear below.
      if (clear) period_cnt_reg <= '0;

      if (commit) begin
        state_reg    <= seed_sh_reg;
        taps_reg     <= taps_sh_reg;
        ref_seed_reg <= seed_sh_reg;
        cnt_reg      <= '0;
      end else if (step_en) begin
        if (state_reg == '0) begin
          state_reg    <= DEFAULT_SEED;
          ref_seed_reg <= DEFAULT_SEED;
          cnt_reg      <= '0;
          lockup_reg   <= 1'b1;
        end else begin
          state_reg <= state_next;
          if (state_next == ref_seed_reg) begin
            period_cnt_reg  <= cnt_next;
            cnt_reg         <= '0;
            period_done_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
      end
    end
  end

  assign state       = state_reg;
  assign bit_out     = mode_reg ? state_reg[0] : state_reg[WIDTH-1];
  assign lockup      = lockup_reg;
  assign period_done = period_done_reg;
  assign period_cnt  = period_cnt_reg;

endmodule

// File: tb/tb_lfsr_prog.sv
// Self-checking bench for lfsr_prog: vector table through a scoreboard queue,
// plus hand-written period, lock-up, clear and reset-mid-run sequences.
module tb_lfsr_prog;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cfg_valid;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        step_en;
  logic [15:0] state;
  logic        bit_out, lockup, period_done;
  logic [31:0] period_cnt;

  logic        cv4;
  logic [1:0]  ca4;
  logic [7:0]  cd4;
  logic        step4;
  logic [3:0]  state4;
  logic        bit4, lock4, pd4;
  logic [31:0] pcnt4;

  int checks = 0;
  int errors = 0;

  lfsr_prog dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .step_en(step_en), .state(state), .bit_out(bit_out),
    .lockup(lockup), .period_done(period_done), .period_cnt(period_cnt)
  );

  lfsr_prog #(.WIDTH(4), .DEFAULT_SEED(4'h1), .DEFAULT_TAPS(4'hC), .DEFAULT_MODE(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cv4), .cfg_addr(ca4),
    .cfg_data(cd4), .step_en(step4), .state(state4), .bit_out(bit4),
    .lockup(lock4), .period_done(pd4), .period_cnt(pcnt4)
  );

  typedef struct packed {
    logic        cv;
    logic [1:0]  ca;
    logic [7:0]  cd;
    logic        st;
    logic [15:0] e_state;
    logic        e_bit;
    logic        e_lock;
    logic        e_pd;
  } vec_t;

  typedef struct packed {
    logic [15:0] s;
    logic        b;
    logic        l;
    logic        p;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[19];

  function automatic vec_t mk(input logic cv, input logic [1:0] ca, input logic [7:0] cd,
                              input logic st, input logic [15:0] es, input logic eb,
                              input logic el, input logic ep);
    vec_t v;
    v.cv = cv; v.ca = ca; v.cd = cd; v.st = st;
    v.e_state = es; v.e_bit = eb; v.e_lock = el; v.e_pd = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    cfg_valid = v.cv; cfg_addr = v.ca; cfg_data = v.cd; step_en = v.st;
    sb_q.push_back({v.e_state, v.e_bit, v.e_lock, v.e_pd});
    tick();
    e = sb_q.pop_front();
    chk($sformatf("vec%0d_state", idx), {16'h0, state}, {16'h0, e.s});
    chk($sformatf("vec%0d_bit", idx), {31'h0, bit_out}, {31'h0, e.b});
    chk($sformatf("vec%0d_lockup", idx), {31'h0, lockup}, {31'h0, e.l});
    chk($sformatf("vec%0d_pdone", idx), {31'h0, period_done}, {31'h0, e.p});
    $display("vec %0d cfg=%0b/%0d/%h step=%0b -> state=%h bit=%0b lockup=%0b pd=%0b",
             idx, v.cv, v.ca, v.cd, v.st, state, bit_out, lockup, period_done);
    cfg_valid = 1'b0; step_en = 1'b0;
  endtask

  initial begin
    int first_pd, second_pd, n;
    bit found;

    // Defaults, then Fibonacci reload, commit-vs-step, zero-seed commit and recovery.
    vecs[0]  = mk(0, 2'd0, 8'h00, 1, 16'hE270, 0, 0, 0);
    vecs[1]  = mk(0, 2'd0, 8'h00, 1, 16'h7138, 0, 0, 0);
    vecs[2]  = mk(1, 2'd0, 8'h80, 0, 16'h7138, 0, 0, 0);
    vecs[3]  = mk(1, 2'd0, 8'h00, 0, 16'h7138, 0, 0, 0);
    vecs[4]  = mk(1, 2'd1, 8'hD0, 0, 16'h7138, 0, 0, 0);
    vecs[5]  = mk(1, 2'd1, 8'h08, 0, 16'h7138, 0, 0, 0);
    vecs[6]  = mk(1, 2'd2, 8'h02, 0, 16'h8000, 1, 0, 0);
    vecs[7]  = mk(0, 2'd0, 8'h00, 1, 16'h0001, 0, 0, 0);
    vecs[8]  = mk(0, 2'd0, 8'h00, 1, 16'h0002, 0, 0, 0);
    vecs[9]  = mk(1, 2'd0, 8'h12, 0, 16'h0002, 0, 0, 0);
    vecs[10] = mk(1, 2'd0, 8'h34, 0, 16'h0002, 0, 0, 0);
    vecs[11] = mk(1, 2'd1, 8'hB4, 0, 16'h0002, 0, 0, 0);
    vecs[12] = mk(1, 2'd1, 8'h00, 0, 16'h0002, 0, 0, 0);
    vecs[13] = mk(1, 2'd2, 8'h03, 1, 16'h1234, 0, 0, 0);
    vecs[14] = mk(0, 2'd0, 8'h00, 1, 16'h091A, 0, 0, 0);
    vecs[15] = mk(1, 2'd0, 8'h00, 0, 16'h091A, 0, 0, 0);
    vecs[16] = mk(1, 2'd0, 8'h00, 0, 16'h091A, 0, 0, 0);
    vecs[17] = mk(1, 2'd2, 8'h03, 0, 16'h0000, 0, 0, 0);
    vecs[18] = mk(0, 2'd0, 8'h00, 1, 16'hACE1, 1, 1, 0);

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = 2'd0; cfg_data = 8'h00; step_en = 1'b0;
    cv4 = 1'b0; ca4 = 2'd0; cd4 = 8'h00; step4 = 1'b0;
    tick(); tick();
    chk("rst_state", {16'h0, state}, 32'hACE1);
    chk("rst_bit", {31'h0, bit_out}, 32'h1);
    chk("rst_lockup", {31'h0, lockup}, 32'h0);
    chk("rst_pdone", {31'h0, period_done}, 32'h0);
    chk("rst_pcnt", period_cnt, 32'h0);
    chk("rst_state4", {28'h0, state4}, 32'h1);
    $display("reset: state=%h bit=%0b state4=%h", state, bit_out, state4);
    rst_n = 1'b1;

    // WIDTH=4 Galois period: pulses after 15 and 30 steps.
    first_pd = 0; second_pd = 0;
    step4 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (pd4) begin
        if (first_pd == 0) begin
          first_pd = i;
          chk("p4_state", {28'h0, state4}, 32'h1);
          chk("p4_pcnt", pcnt4, 32'd15);
        end else if (second_pd == 0) begin
          second_pd = i;
          chk("p4_pcnt2", pcnt4, 32'd15);
        end
      end
    end
    step4 = 1'b0;
    chk("p4_first_step", first_pd, 32'd15);
    chk("p4_second_step", second_pd, 32'd30);
    $display("width4 period: first=%0d second=%0d", first_pd, second_pd);

    for (int i = 0; i < 19; i++) apply(i, vecs[i]);

    // Full 16-bit period from the recovered seed.
    found = 1'b0; n = 0;
    step_en = 1'b1;
    for (int i = 1; i <= 70000 && !found; i++) begin
      tick();
      if (i == 1) chk("lockup_one_cycle", {31'h0, lockup}, 32'h0);
      if (period_done) begin
        found = 1'b1;
        n = i;
      end
    end
    step_en = 1'b0;
    chk("lk_period_steps", n, 32'd65535);
    chk("lk_period_state", {16'h0, state}, 32'hACE1);
    chk("lk_period_cnt", period_cnt, 32'd65535);
    $display("lockup period: steps=%0d period_cnt=%0d", n, period_cnt);
    tick();
    chk("pdone_one_cycle", {31'h0, period_done}, 32'h0);

    // Clear period_cnt, keeping Galois mode.
    cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 8'h05;
    tick();
    cfg_valid = 1'b0;
    chk("clear_pcnt", period_cnt, 32'h0);
    chk("clear_state", {16'h0, state}, 32'hACE1);
    $display("clear: period_cnt=%0d", period_cnt);

    // Reset mid-run discards state and shadows.
    step_en = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    step_en = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_state", {16'h0, state}, 32'hACE1);
    chk("mid_rst_bit", {31'h0, bit_out}, 32'h1);
    chk("mid_rst_pcnt", period_cnt, 32'h0);
    chk("mid_rst_pdone", {31'h0, period_done}, 32'h0);
    $display("mid-run reset: state=%h", state);
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
    chk("mid_rst_step", {16'h0, state}, 32'hE270);
    cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 8'h03;
    tick();
    cfg_valid = 1'b0;
    chk("mid_rst_shadow", {16'h0, state}, 32'h0000);
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
    chk("mid_rst_recover", {16'h0, state}, 32'hACE1);
    chk("mid_rst_lockup", {31'h0, lockup}, 32'h1);
    $display("post-reset commit/recover: state=%h lockup=%0b", state, lockup);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_prog.md
# lfsr_prog

Runtime-programmable LFSR engine, the parametrised successor to the fixed-polynomial LFSR in our tapeout project. Width, reset seed and reset polynomial are parameters; seed, tap mask and Fibonacci/Galois mode are reloaded at runtime through a byte-serial config port. It also recovers automatically from the all-zero lock-up state and measures the sequence period in hardware. It sits behind the tile's `ui_in`/`uio_in` pins; `state` and `bit_out` drive `uo_out`.

## Interface
- `WIDTH`, 16: LFSR length, legal range 4..32.
- `DEFAULT_SEED`, 16'hACE1: seed applied at reset and on lock-up recovery; must be non-zero.
- `DEFAULT_TAPS`, 16'hB400: tap mask applied at reset.
- `DEFAULT_MODE`, 1: mode at reset; 0 = Fibonacci, 1 = Galois.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cfg_valid`  in  1  config byte write strobe.
- `cfg_addr`  in  2  config target: 0 = seed shadow, 1 = taps shadow, 2 = control, 3 = ignored.
- `cfg_data`  in  8  config byte.
- `step_en`  in  1  advance one step this cycle.
- `state`  out  WIDTH  current LFSR register.
- `bit_out`  out  1  output bit of the current state.
- `lockup`  out  1  one-cycle pulse when an all-zero state was replaced by `DEFAULT_SEED`.
- `period_done`  out  1  one-cycle pulse when a step returns the state to the reference seed.
- `period_cnt`  out  32  step count of the last completed period.

## Operation
- Registers:
  - active `state`, `taps` and `mode`;
  - shadow `seed_sh` and `taps_sh`;
  - reference seed `ref_seed`;
  - 32-bit step counter `cnt`.
- Config write (`cfg_valid`=1):
  - addr 0: `seed_sh` <= low WIDTH bits of {`seed_sh`, `cfg_data`}. Bytes go MSB first.
  - addr 1: same shift into `taps_sh`.
  - addr 2: bit0 -> `mode`, taking effect immediately. bit1 = commit. bit2 = clear `period_cnt`. Bits 7:3 are ignored.
- Commit: `state` <= `seed_sh`, `taps` <= `taps_sh`, `ref_seed` <= `seed_sh`, `cnt` <= 0. Shadows keep their values.
- Fibonacci step:
  - `fb` = XOR-reduce(`state` & `taps`).
  - next = {`state`[WIDTH-2:0], `fb`}.
  - `bit_out` = `state`[WIDTH-1].
- Galois step:
  - next = (`state` >> 1) ^ (`state`[0] ? `taps` : 0).
  - `bit_out` = `state`[0].
- Lock-up: a step while `state` == 0 loads `DEFAULT_SEED` instead of the computed next value. The same step sets `ref_seed` <= `DEFAULT_SEED`, sets `cnt` <= 0 and pulses `lockup`. A zero seed may be committed; recovery happens on the first step after it.
- Period: on each normal step, `cnt` <= `cnt`+1.
  - If next == `ref_seed`: `period_cnt` <= `cnt`+1, `cnt` <= 0, and `period_done` pulses.
  - `cnt` and `period_cnt` wrap modulo 2^32.
- Priority, same cycle: reset > commit > step. A step requested together with a commit is dropped. Clear (bit2) and `period_done` in the same cycle: `period_done` wins, and the new value is latched.

## Timing
- Reset, cycle after `rst_n`=0 is sampled low:
  - `state` = `ref_seed` = `DEFAULT_SEED`; `taps` = `DEFAULT_TAPS`; `mode` = `DEFAULT_MODE`;
  - shadows = 0; `cnt` = `period_cnt` = 0; `lockup` = `period_done` = 0.
  - `bit_out` then follows from `state`.
- Reset mid-sequence or mid-config discards the in-progress state and shadows. No partial commit.
- Step, commit and config writes take effect at the clock edge. New `state` is visible the cycle after the request.
- `step_en` held high advances one step every cycle, with no bubbles.
- `lockup` and `period_done` are registered. They are high exactly in the cycle in which the corresponding new `state` is visible.
- `bit_out` is combinational from the registered `state` and `mode`; there is no extra latency.
- A mode change without a commit applies from the next step, using the current state.

## Test plan
- Reset, defaults (WIDTH=16): release `rst_n`, step twice -> `state` goes 0xACE1 -> 0xE270 -> 0x7138. `bit_out` is 1, 0, 0 across the three states.
- Fibonacci reload:
  - Write seed bytes 0x80, 0x00; taps 0xD0, 0x08; control 0x02.
  - Next cycle `state`=0x8000, `bit_out`=1.
  - Step -> 0x0001. Step -> 0x0002.
- Period, WIDTH=4, `DEFAULT_TAPS`=4'hC, `DEFAULT_SEED`=4'h1, Galois: hold `step_en` -> `period_done` pulses after exactly 15 steps with `state`=0x1 and `period_cnt`=15, then again 15 steps later.
- Lock-up: commit seed 0x0000 with taps 0xB400. `state`=0. Step -> `state`=0xACE1 and `lockup`=1 for one cycle. The next 65535 steps give `period_done` with `period_cnt`=65535.
- Commit vs step: assert commit (seed 0x1234) and `step_en` in the same cycle -> `state`=0x1234 and no step is taken. Then step (Galois, 0xB400) -> 0x091A.
- Reset mid-run: after 100 steps, pulse `rst_n` low for one cycle -> all outputs at reset values, and the 0xE270 sequence restarts.
